// File: rtl/normal_eq_builder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | normal_eq_builder: accumulates LSM normal equations for basis {1,x,x^2}  |
// | and presents [X'X | X'y] row-major. Optional macro: ITM_FILTER_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module normal_eq_builder #(
  parameter int WIDTH     = 32,
  parameter int QINT      = 16,
  parameter int QFRAC     = 16,
  parameter int ACC_WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sample_itm,
  input  logic             sample_last,
  output logic             mat_valid,
  input  logic             mat_ready,
  output logic [WIDTH-1:0] mat_flat [0:11],
  output logic             sat_flag
);

  localparam logic [1:0] c_ACCUM   = 2'd0;
  localparam logic [1:0] c_DRAIN   = 2'd1;
  localparam logic [1:0] c_PRESENT = 2'd2;

  localparam int     c_SHIFT = WIDTH - QINT;
  localparam longint c_EMAX  = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint c_EMIN  = -(longint'(1) <<< (WIDTH - 1));
  localparam logic signed [ACC_WIDTH-1:0] c_ONE = ACC_WIDTH'(longint'(1) <<< QFRAC);

  // Result is {saturated, value}
  function automatic logic [WIDTH:0] mul_q(input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    p = p >>> c_SHIFT;
    if (p > (2*WIDTH)'(c_EMAX))      return {1'b1, WIDTH'(c_EMAX)};
    else if (p < (2*WIDTH)'(c_EMIN)) return {1'b1, WIDTH'(c_EMIN)};
    else                             return {1'b0, WIDTH'(p)};
  endfunction

  function automatic logic [WIDTH:0] clamp_acc(input logic signed [ACC_WIDTH-1:0] a);
    if (a > ACC_WIDTH'(c_EMAX))      return {1'b1, WIDTH'(c_EMAX)};
    else if (a < ACC_WIDTH'(c_EMIN)) return {1'b1, WIDTH'(c_EMIN)};
    else                             return {1'b0, WIDTH'(a)};
  endfunction

  logic [1:0] state_q, state_d;
  logic p1_valid_q, p1_valid_d, p1_use_q, p1_use_d, p1_sat_q, p1_sat_d;
  logic signed [WIDTH-1:0] p1_x_q, p1_x_d, p1_y_q, p1_y_d;
  logic signed [WIDTH-1:0] p1_x2_q, p1_x2_d, p1_xy_q, p1_xy_d;
  logic p2_valid_q, p2_valid_d, p2_use_q, p2_use_d, p2_sat_q, p2_sat_d;
  logic signed [WIDTH-1:0] p2_x_q, p2_x_d, p2_y_q, p2_y_d, p2_x2_q, p2_x2_d;
  logic signed [WIDTH-1:0] p2_xy_q, p2_xy_d, p2_x3_q, p2_x3_d;
  logic signed [WIDTH-1:0] p2_x4_q, p2_x4_d, p2_x2y_q, p2_x2y_d;
  logic signed [ACC_WIDTH-1:0] s_acc_q [0:4];
  logic signed [ACC_WIDTH-1:0] s_acc_d [0:4];
  logic signed [ACC_WIDTH-1:0] t_acc_q [0:2];
  logic signed [ACC_WIDTH-1:0] t_acc_d [0:2];
  logic prod_sat_q, prod_sat_d, sat_flag_q, sat_flag_d;
  logic [WIDTH-1:0] mat_flat_q [0:11];
  logic [WIDTH-1:0] mat_flat_d [0:11];

  logic w_accept, w_use, w_commit, w_any_clamp;
  logic [WIDTH:0] w_x2, w_xy, w_x3, w_x4, w_x2y;
  logic [WIDTH:0] w_s_full [0:4];
  logic [WIDTH:0] w_t_full [0:2];

  assign sample_ready = (state_q == c_ACCUM);
  assign mat_valid    = (state_q == c_PRESENT);
  assign mat_flat     = mat_flat_q;
  assign sat_flag     = sat_flag_q;
  assign w_accept     = sample_valid & sample_ready;
  assign w_commit     = (state_q == c_DRAIN) & ~p1_valid_q & ~p2_valid_q;

`ifdef ITM_FILTER_EN
  assign w_use = sample_itm;
`else
  // Out-of-money paths are regressed too; the flag is deliberately ignored.
  assign w_use = sample_itm | 1'b1;
`endif

  assign w_x2  = mul_q(x, x);
  assign w_xy  = mul_q(x, y);
  assign w_x3  = mul_q(p1_x2_q, p1_x_q);
  assign w_x4  = mul_q(p1_x2_q, p1_x2_q);
  assign w_x2y = mul_q(p1_x2_q, p1_y_q);

  for (genvar k = 0; k < 5; k++) begin : g_s_clamp
    assign w_s_full[k] = clamp_acc(s_acc_q[k]);
  end
  for (genvar k = 0; k < 3; k++) begin : g_t_clamp
    assign w_t_full[k] = clamp_acc(t_acc_q[k]);
  end

  assign w_any_clamp = w_s_full[0][WIDTH] | w_s_full[1][WIDTH] | w_s_full[2][WIDTH] |
                       w_s_full[3][WIDTH] | w_s_full[4][WIDTH] | w_t_full[0][WIDTH] |
                       w_t_full[1][WIDTH] | w_t_full[2][WIDTH];

  always_comb begin
    state_d    = state_q;
    p1_valid_d = w_accept;
    p1_use_d   = w_accept & w_use;
    p1_sat_d   = w_x2[WIDTH] | w_xy[WIDTH];
    p1_x_d     = x;
    p1_y_d     = y;
    p1_x2_d    = w_x2[WIDTH-1:0];
    p1_xy_d    = w_xy[WIDTH-1:0];
    p2_valid_d = p1_valid_q;
    p2_use_d   = p1_use_q;
    p2_sat_d   = p1_sat_q | w_x3[WIDTH] | w_x4[WIDTH] | w_x2y[WIDTH];
    p2_x_d     = p1_x_q;
    p2_y_d     = p1_y_q;
    p2_x2_d    = p1_x2_q;
    p2_xy_d    = p1_xy_q;
    p2_x3_d    = w_x3[WIDTH-1:0];
    p2_x4_d    = w_x4[WIDTH-1:0];
    p2_x2y_d   = w_x2y[WIDTH-1:0];
    s_acc_d    = s_acc_q;
    t_acc_d    = t_acc_q;
    prod_sat_d = prod_sat_q;
    sat_flag_d = sat_flag_q;
    mat_flat_d = mat_flat_q;

    if (p2_use_q) begin
      s_acc_d[0] = s_acc_q[0] + c_ONE;
      s_acc_d[1] = s_acc_q[1] + ACC_WIDTH'(p2_x_q);
      s_acc_d[2] = s_acc_q[2] + ACC_WIDTH'(p2_x2_q);
      s_acc_d[3] = s_acc_q[3] + ACC_WIDTH'(p2_x3_q);
      s_acc_d[4] = s_acc_q[4] + ACC_WIDTH'(p2_x4_q);
      t_acc_d[0] = t_acc_q[0] + ACC_WIDTH'(p2_y_q);
      t_acc_d[1] = t_acc_q[1] + ACC_WIDTH'(p2_xy_q);
      t_acc_d[2] = t_acc_q[2] + ACC_WIDTH'(p2_x2y_q);
      prod_sat_d = prod_sat_q | p2_sat_q;
    end

    case (state_q)
      c_ACCUM: begin
        if (w_accept && sample_last) state_d = c_DRAIN;
      end
      c_DRAIN: begin
        if (w_commit) begin
          state_d    = c_PRESENT;
          sat_flag_d = prod_sat_q | w_any_clamp;
          for (int i = 0; i < 3; i++) begin
            mat_flat_d[i*4+0] = w_s_full[i][WIDTH-1:0];
            mat_flat_d[i*4+1] = w_s_full[i+1][WIDTH-1:0];
            mat_flat_d[i*4+2] = w_s_full[i+2][WIDTH-1:0];
            mat_flat_d[i*4+3] = w_t_full[i][WIDTH-1:0];
          end
        end
      end
      c_PRESENT: begin
        if (mat_ready) begin
          state_d    = c_ACCUM;
          sat_flag_d = 1'b0;
          prod_sat_d = 1'b0;
          p1_valid_d = 1'b0;
          p1_use_d   = 1'b0;
          p2_valid_d = 1'b0;
          p2_use_d   = 1'b0;
          for (int k = 0; k < 5; k++) s_acc_d[k] = '0;
          for (int k = 0; k < 3; k++) t_acc_d[k] = '0;
        end
      end
      default: state_d = c_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_ACCUM;
      p1_valid_q <= 1'b0;  p1_use_q <= 1'b0;  p1_sat_q <= 1'b0;
      p1_x_q     <= '0;    p1_y_q   <= '0;    p1_x2_q  <= '0;  p1_xy_q <= '0;
      p2_valid_q <= 1'b0;  p2_use_q <= 1'b0;  p2_sat_q <= 1'b0;
      p2_x_q     <= '0;    p2_y_q   <= '0;    p2_x2_q  <= '0;  p2_xy_q <= '0;
      p2_x3_q    <= '0;    p2_x4_q  <= '0;    p2_x2y_q <= '0;
      for (int k = 0; k < 5; k++)  s_acc_q[k]    <= '0;
      for (int k = 0; k < 3; k++)  t_acc_q[k]    <= '0;
      for (int k = 0; k < 12; k++) mat_flat_q[k] <= '0;
      prod_sat_q <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_valid_q <= p1_valid_d;  p1_use_q <= p1_use_d;  p1_sat_q <= p1_sat_d;
      p1_x_q     <= p1_x_d;      p1_y_q   <= p1_y_d;    p1_x2_q  <= p1_x2_d;  p1_xy_q <= p1_xy_d;
      p2_valid_q <= p2_valid_d;  p2_use_q <= p2_use_d;  p2_sat_q <= p2_sat_d;
      p2_x_q     <= p2_x_d;      p2_y_q   <= p2_y_d;    p2_x2_q  <= p2_x2_d;  p2_xy_q <= p2_xy_d;
      p2_x3_q    <= p2_x3_d;     p2_x4_q  <= p2_x4_d;   p2_x2y_q <= p2_x2y_d;
      s_acc_q    <= s_acc_d;
      t_acc_q    <= t_acc_d;
      mat_flat_q <= mat_flat_d;
      prod_sat_q <= prod_sat_d;
      sat_flag_q <= sat_flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_normal_eq_builder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_normal_eq_builder: directed self-checking bench for normal_eq_builder |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_normal_eq_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [31:0] sx = '0;
  logic [31:0] sy = '0;
  logic        sample_itm = 1'b1;
  logic        sample_last = 1'b0;
  logic        mat_valid;
  logic        mat_ready = 1'b1;
  logic [31:0] mat_flat [0:11];
  logic        sat_flag;

  int vectors = 0;
  int miscompares = 0;

  normal_eq_builder dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x            (sx),
    .y            (sy),
    .sample_itm   (sample_itm),
    .sample_last  (sample_last),
    .mat_valid    (mat_valid),
    .mat_ready    (mat_ready),
    .mat_flat     (mat_flat),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] q(input int v);
    return 32'(v <<< 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int vx, input int vy, input logic itm, input logic last);
    int n;
    n = 0;
    sx = q(vx);
    sy = q(vy);
    sample_itm = itm;
    sample_last = last;
    sample_valid = 1'b1;
    while (!sample_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(sample_ready), 32'd1);
    tick();
    sample_valid = 1'b0;
    sample_last = 1'b0;
  endtask

  task automatic wait_mat();
    int n;
    n = 0;
    while (!mat_valid && n < 20) begin
      tick();
      n++;
    end
    chk("mat_valid_wait", 32'(mat_valid), 32'd1);
  endtask

  task automatic chk_matrix(input string tag, input int m [12]);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s_m%0d", tag, i), mat_flat[i], q(m[i]));
  endtask

  initial begin
    int m1 [12] = '{3, 6, 14, 12, 6, 14, 36, 28, 14, 36, 98, 72};
    int m5 [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int m6 [12] = '{1, -1, 1, -2, -1, 1, -1, 2, 1, -1, 1, -2};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sample_ready", 32'(sample_ready), 32'd1);
    chk("rst_mat_valid", 32'(mat_valid), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    chk("rst_mat0", mat_flat[0], 32'd0);
    chk("rst_mat11", mat_flat[11], 32'd0);

    // Test 1: basic batch with latency check
    mat_ready = 1'b1;
    send(1, 2, 1'b1, 1'b0);
    send(2, 4, 1'b1, 1'b0);
    send(3, 6, 1'b1, 1'b1);
    chk("t1_drain_ready", 32'(sample_ready), 32'd0);
    tick();
    tick();
    chk("t1_lat_t3", 32'(mat_valid), 32'd0);
    tick();
    chk("t1_lat_t4", 32'(mat_valid), 32'd1);
    chk_matrix("t1", m1);
    chk("t1_sat", 32'(sat_flag), 32'd0);
    tick();
    chk("t1_after_valid", 32'(mat_valid), 32'd0);
    chk("t1_after_ready", 32'(sample_ready), 32'd1);

    // Test 2: backpressure, with a sample offered while presenting
    mat_ready = 1'b0;
    send(1, 2, 1'b1, 1'b0);
    send(2, 4, 1'b1, 1'b0);
    send(3, 6, 1'b1, 1'b1);
    wait_mat();
    sx = q(7);
    sy = q(7);
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_hold_valid_%0d", i), 32'(mat_valid), 32'd1);
      chk($sformatf("t2_hold_ready_%0d", i), 32'(sample_ready), 32'd0);
      chk($sformatf("t2_hold_t0_%0d", i), mat_flat[3], q(12));
      chk($sformatf("t2_hold_s4_%0d", i), mat_flat[10], q(98));
      tick();
    end
    sample_valid = 1'b0;
    mat_ready = 1'b1;
    tick();
    chk("t2_one_transfer", 32'(mat_valid), 32'd0);
    chk("t2_ready_back", 32'(sample_ready), 32'd1);

    // Test 3: product saturation and element clamp
    send(20, 1, 1'b1, 1'b0);
    send(20, 1, 1'b1, 1'b1);
    wait_mat();
    chk("t3_s4", mat_flat[10], 32'h7FFF_FFFF);
    chk("t3_n", mat_flat[0], 32'h0002_0000);
    chk("t3_sat", 32'(sat_flag), 32'd1);
    tick();

    // Test 4: ITM flag handling
    send(1, 1, 1'b1, 1'b0);
    send(5, 1, 1'b0, 1'b0);
    send(2, 1, 1'b1, 1'b0);
    send(5, 1, 1'b0, 1'b1);
    wait_mat();
`ifdef ITM_FILTER_EN
    chk("t4_n", mat_flat[0], q(2));
    chk("t4_s1", mat_flat[1], q(3));
`else
    chk("t4_n", mat_flat[0], q(4));
    chk("t4_s1", mat_flat[1], q(13));
`endif
    chk("t4_sat_cleared", 32'(sat_flag), 32'd0);
    tick();

    // Test 5: reset discards a partial batch
    send(3, 3, 1'b1, 1'b0);
    send(4, 4, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ready", 32'(sample_ready), 32'd1);
    chk("t5_rst_valid", 32'(mat_valid), 32'd0);
    chk("t5_rst_mat0", mat_flat[0], 32'd0);
    send(1, 1, 1'b1, 1'b1);
    wait_mat();
    chk_matrix("t5", m5);
    tick();

    // Test 6: negative operands
    send(-1, -2, 1'b1, 1'b1);
    wait_mat();
    chk_matrix("t6", m6);
    chk("t6_sat", 32'(sat_flag), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
